// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage owning the PC, tracking the 1-cycle imem read, with a stall skid buffer and the IF/ID register
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        if_misalign
);
  typedef enum logic {RUN, TRAP} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d, skid_pc_q, skid_pc_d;
  logic [31:0] if_inst_q, if_inst_d, if_pc_q, if_pc_d;
  logic        req_vld_q, req_vld_d, req_mis_q, req_mis_d;
  logic        skid_vld_q, skid_vld_d, skid_mis_q, skid_mis_d;
  logic        if_valid_q, if_valid_d, if_mis_q, if_mis_d;
  logic        issue, aligned;
  logic [31:0] rsp_inst;

  assign issue       = ~stall_i & ~redirect_i & (state_q == RUN);
  assign aligned     = pc_q[1:0] == 2'b00;
  assign imem_rd_en  = rst_n & issue & aligned;
  assign imem_addr   = pc_q;
  assign rsp_inst    = req_mis_q ? NOP_INST : imem_rdata;
  assign if_inst     = if_inst_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_q + 32'd4;
  assign if_valid    = if_valid_q;
  assign if_misalign = if_mis_q;

  // FSM state register: RUN fetches, TRAP parks after a misaligned target
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;

  // FSM next state: redirect always returns to RUN, a misaligned issue traps
  always_comb begin
    state_d = state_q;
    if (redirect_i)             state_d = RUN;
    else if (issue && !aligned) state_d = TRAP;
  end

  // Datapath next state: PC advance, request tracking, skid capture and IF/ID load
  always_comb begin
    pc_d        = pc_q;
    req_vld_d   = 1'b0;
    req_pc_d    = req_pc_q;
    req_mis_d   = req_mis_q;
    skid_vld_d  = skid_vld_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_mis_d  = skid_mis_q;
    if_valid_d  = if_valid_q;
    if_inst_d   = if_inst_q;
    if_pc_d     = if_pc_q;
    if_mis_d    = if_mis_q;
    if (redirect_i) begin
      pc_d       = redirect_pc_i;
      skid_vld_d = 1'b0;
      if_valid_d = 1'b0;
      if_mis_d   = 1'b0;
      if_inst_d  = NOP_INST;
    end else begin
      if (issue) begin
        req_vld_d = 1'b1;
        req_pc_d  = pc_q;
        req_mis_d = ~aligned;
        pc_d      = aligned ? pc_q + 32'd4 : pc_q;
      end
      if (stall_i) begin
        if (req_vld_q && !skid_vld_q) begin
          skid_vld_d  = 1'b1;
          skid_inst_d = rsp_inst;
          skid_pc_d   = req_pc_q;
          skid_mis_d  = req_mis_q;
        end
      end else if (skid_vld_q) begin
        skid_vld_d = 1'b0;
        if_valid_d = 1'b1;
        if_inst_d  = skid_inst_q;
        if_pc_d    = skid_pc_q;
        if_mis_d   = skid_mis_q;
      end else begin
        if_valid_d = req_vld_q;
        if_inst_d  = req_vld_q ? rsp_inst : NOP_INST;
        if_pc_d    = req_vld_q ? req_pc_q : if_pc_q;
        if_mis_d   = req_vld_q & req_mis_q;
      end
    end
  end

  // Datapath registers, discarded immediately on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      req_vld_q   <= 1'b0;
      req_pc_q    <= 32'd0;
      req_mis_q   <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_inst_q <= NOP_INST;
      skid_pc_q   <= 32'd0;
      skid_mis_q  <= 1'b0;
      if_valid_q  <= 1'b0;
      if_inst_q   <= NOP_INST;
      if_pc_q     <= 32'd0;
      if_mis_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_vld_q   <= req_vld_d;
      req_pc_q    <= req_pc_d;
      req_mis_q   <= req_mis_d;
      skid_vld_q  <= skid_vld_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_mis_q  <= skid_mis_d;
      if_valid_q  <= if_valid_d;
      if_inst_q   <= if_inst_d;
      if_pc_q     <= if_pc_d;
      if_mis_q    <= if_mis_d;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a queue-based fetch/delivery model
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        rd1, rd2;
  logic [31:0] addr1, addr2, rdata1, rdata2;
  logic [31:0] inst1, pc1, pc41, inst2, pc2, pc42;
  logic        valid1, mis1, valid2, mis2;
  int          total = 0, bad = 0;

  typedef struct packed {logic [31:0] pc; int cyc; logic mis;} fetch_t;
  fetch_t      m_q[$];
  logic [31:0] m_pc, m_if_pc, m_if_inst;
  logic        m_trap, m_if_valid, m_if_mis;
  int          m_cyc;
  logic        e_rd, e_valid, e_mis;
  logic [31:0] e_addr, e_pc, e_inst;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_rd_en(rd1), .imem_addr(addr1), .imem_rdata(rdata1),
    .if_inst(inst1), .if_pc(pc1), .if_pc_plus4(pc41), .if_valid(valid1), .if_misalign(mis1));

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_rd_en(rd2), .imem_addr(addr2), .imem_rdata(rdata2),
    .if_inst(inst2), .if_pc(pc2), .if_pc_plus4(pc42), .if_valid(valid2), .if_misalign(mis2));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  // Synchronous instruction memory with one cycle of read latency
  always @(posedge clk) begin
    if (rd1) rdata1 <= mem_word(addr1);
    if (rd2) rdata2 <= mem_word(addr2);
  end

  // A response must never arrive while the skid buffer still holds one
  always @(negedge clk)
    if (rst_n && dut.skid_vld_q && dut.req_vld_q) begin
      bad++;
      $display("FAIL skid_invariant: skid full and response present together, required never both");
    end

  task automatic m_reset();
    m_q.delete();
    m_pc = 32'h100; m_trap = 1'b0; m_cyc = 0;
    m_if_valid = 1'b0; m_if_pc = 32'd0; m_if_inst = NOP; m_if_mis = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    m_reset();
    @(posedge clk);
  endtask

  // One cycle: drive inputs, snapshot model expectations for this cycle, advance model, sample at negedge
  task automatic step(input logic s, input logic r, input logic [31:0] t);
    fetch_t f;
    @(posedge clk); #1;
    rst_n = 1'b1; stall_i = s; redirect_i = r; redirect_pc_i = t;
    m_cyc++;
    e_rd = !s && !r && !m_trap && m_pc[1:0] == 2'b00; e_addr = m_pc;
    e_valid = m_if_valid; e_pc = m_if_pc; e_inst = m_if_inst; e_mis = m_if_mis;
    if (r) begin
      m_q.delete(); m_pc = t; m_trap = 1'b0;
      m_if_valid = 1'b0; m_if_inst = NOP; m_if_mis = 1'b0;
    end else if (!s) begin
      if (m_q.size() > 0 && m_q[0].cyc < m_cyc) begin
        f = m_q.pop_front();
        m_if_valid = 1'b1; m_if_pc = f.pc; m_if_mis = f.mis; m_if_inst = f.mis ? NOP : mem_word(f.pc);
      end else begin
        m_if_valid = 1'b0; m_if_inst = NOP; m_if_mis = 1'b0;
      end
      if (!m_trap) begin
        m_q.push_back('{pc: m_pc, cyc: m_cyc, mis: m_pc[1:0] != 2'b00});
        if (m_pc[1:0] == 2'b00) m_pc = m_pc + 32'd4;
        else m_trap = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; #1;
    rst_n = 1'b0; #1;
    total++;
    if ({valid1, mis1, rd1, inst1, pc1, pc41} !== {3'b000, NOP, 32'h0, 32'h4}) begin
      bad++;
      $display("FAIL reset_dut: got v=%b m=%b rd=%b inst=%h pc=%h pc4=%h, required 0 0 0 %h 0 4", valid1, mis1, rd1, inst1, pc1, pc41, NOP);
    end
    total++;
    if ({valid2, mis2, rd2, inst2, pc2, pc42} !== {3'b000, NOP, 32'h0, 32'h4}) begin
      bad++;
      $display("FAIL reset_dut2: got v=%b m=%b rd=%b inst=%h pc=%h pc4=%h, required 0 0 0 %h 0 4", valid2, mis2, rd2, inst2, pc2, pc42, NOP);
    end
    m_reset();
    @(posedge clk);
  endtask

  task automatic test_sequence();
    logic [31:0] p;
    do_reset();
    for (int n = 1; n <= 6; n++) begin
      step(1'b0, 1'b0, 32'd0);
      p = 32'h100 + 32'(4 * (n - 1));
      total++;
      if (rd1 !== 1'b1 || addr1 !== p) begin
        bad++; $display("FAIL seq_fetch c%0d: rd=%b addr=%h, required 1 %h", n, rd1, addr1, p);
      end
      p = 32'h100 + 32'(4 * (n - 3));
      total++;
      if (n < 3 && valid1 !== 1'b0) begin
        bad++; $display("FAIL seq_early_valid c%0d: valid=%b, required 0", n, valid1);
      end else if (n >= 3 && {valid1, mis1, pc1, inst1, pc41} !== {2'b10, p, mem_word(p), p + 32'd4}) begin
        bad++; $display("FAIL seq_out c%0d: v=%b m=%b pc=%h inst=%h pc4=%h, required 1 0 %h %h %h", n, valid1, mis1, pc1, inst1, pc41, p, mem_word(p), p + 32'd4);
      end
    end
  endtask

  task automatic test_stall(input int len);
    logic [31:0] p;
    logic        st, er;
    do_reset();
    for (int n = 1; n <= 8 + len; n++) begin
      st = n >= 5 && n <= 4 + len;
      step(st, 1'b0, 32'd0);
      er = !st;
      p = 32'h100 + 32'(4 * (n <= 4 ? n - 1 : n - 1 - len));
      total++;
      if (rd1 !== er || (er && addr1 !== p)) begin
        bad++; $display("FAIL stall%0d_fetch c%0d: rd=%b addr=%h, required %b %h", len, n, rd1, addr1, er, p);
      end
      if (n >= 3) begin
        p = n <= 5 ? 32'h100 + 32'(4 * (n - 3)) : (n <= 5 + len ? 32'h108 : 32'h108 + 32'(4 * (n - 5 - len)));
        total++;
        if ({valid1, pc1, inst1} !== {1'b1, p, mem_word(p)}) begin
          bad++; $display("FAIL stall%0d_out c%0d: v=%b pc=%h inst=%h, required 1 %h %h", len, n, valid1, pc1, inst1, p, mem_word(p));
        end
      end
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    repeat (4) step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h200);
    total++;
    if (rd1 !== 1'b0) begin bad++; $display("FAIL redir_no_fetch: rd=%b, required 0", rd1); end
    step(1'b0, 1'b0, 32'd0);
    total++;
    if (valid1 !== 1'b0 || rd1 !== 1'b1 || addr1 !== 32'h200) begin
      bad++; $display("FAIL redir_t1: v=%b rd=%b addr=%h, required 0 1 00000200", valid1, rd1, addr1);
    end
    step(1'b0, 1'b0, 32'd0);
    total++;
    if (valid1 !== 1'b0) begin bad++; $display("FAIL redir_t2: v=%b pc=%h, required invalid", valid1, pc1); end
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 32'd0);
      total++;
      if ({valid1, pc1, inst1} !== {1'b1, 32'h200 + 32'(4 * k), mem_word(32'h200 + 32'(4 * k))}) begin
        bad++; $display("FAIL redir_out%0d: v=%b pc=%h inst=%h, required 1 %h", k, valid1, pc1, inst1, 32'h200 + 32'(4 * k));
      end
    end
  endtask

  task automatic test_misalign();
    do_reset();
    repeat (4) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h202);
    for (int n = 6; n <= 11; n++) begin
      step(1'b0, 1'b0, 32'd0);
      total++;
      if (rd1 !== 1'b0) begin bad++; $display("FAIL mis_fetch c%0d: rd=%b, required 0", n, rd1); end
      total++;
      if (n == 8 && {valid1, mis1, pc1, inst1, pc41} !== {2'b11, 32'h202, NOP, 32'h206}) begin
        bad++; $display("FAIL mis_entry: v=%b m=%b pc=%h inst=%h pc4=%h, required 1 1 00000202 %h 00000206", valid1, mis1, pc1, inst1, pc41, NOP);
      end else if (n != 8 && valid1 !== 1'b0) begin
        bad++; $display("FAIL mis_invalid c%0d: v=%b, required 0", n, valid1);
      end
    end
    step(1'b0, 1'b1, 32'h300);
    step(1'b0, 1'b0, 32'd0);
    total++;
    if (rd1 !== 1'b1 || addr1 !== 32'h300) begin
      bad++; $display("FAIL mis_resume: rd=%b addr=%h, required 1 00000300", rd1, addr1);
    end
    repeat (2) step(1'b0, 1'b0, 32'd0);
    total++;
    if ({valid1, mis1, pc1, inst1} !== {2'b10, 32'h300, mem_word(32'h300)}) begin
      bad++; $display("FAIL mis_resume_out: v=%b m=%b pc=%h inst=%h, required 1 0 00000300", valid1, mis1, pc1, inst1);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1'b0, 1'b0, 32'd0);
    total++;
    if (rd2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_fetch0: rd=%b addr=%h, required 1 fffffffc", rd2, addr2); end
    step(1'b0, 1'b0, 32'd0);
    total++;
    if (rd2 !== 1'b1 || addr2 !== 32'h0) begin bad++; $display("FAIL wrap_fetch1: rd=%b addr=%h, required 1 00000000", rd2, addr2); end
    step(1'b0, 1'b0, 32'd0);
    total++;
    if ({valid2, pc2, pc42, inst2} !== {1'b1, 32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC)}) begin
      bad++; $display("FAIL wrap_out0: v=%b pc=%h pc4=%h inst=%h, required 1 fffffffc 00000000 %h", valid2, pc2, pc42, inst2, mem_word(32'hFFFF_FFFC));
    end
    step(1'b0, 1'b0, 32'd0);
    total++;
    if ({valid2, pc2, pc42, inst2} !== {1'b1, 32'h0, 32'h4, mem_word(32'h0)}) begin
      bad++; $display("FAIL wrap_out1: v=%b pc=%h pc4=%h inst=%h, required 1 0 4 %h", valid2, pc2, pc42, inst2, mem_word(32'h0));
    end
    #2;
    test_reset();
  endtask

  task automatic test_random();
    logic        s, r;
    logic [31:0] t;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      s = $urandom_range(0, 99) < 25;
      r = $urandom_range(0, 99) < 6;
      t = $urandom;
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      step(s, r, t);
      total++;
      if (rd1 !== e_rd || (e_rd && addr1 !== e_addr)) begin
        bad++; $display("FAIL rand_fetch c%0d: rd=%b addr=%h, required %b %h", m_cyc, rd1, addr1, e_rd, e_addr);
      end
      total++;
      if (valid1 !== e_valid) begin
        bad++; $display("FAIL rand_valid c%0d: v=%b, required %b (pc %h)", m_cyc, valid1, e_valid, e_pc);
      end else if (e_valid && {pc1, inst1, mis1, pc41} !== {e_pc, e_inst, e_mis, e_pc + 32'd4}) begin
        bad++; $display("FAIL rand_entry c%0d: pc=%h inst=%h m=%b pc4=%h, required %h %h %b %h", m_cyc, pc1, inst1, mis1, pc41, e_pc, e_inst, e_mis, e_pc + 32'd4);
      end else if (!e_valid && inst1 !== NOP) begin
        bad++; $display("FAIL rand_bubble c%0d: inst=%h, required %h", m_cyc, inst1, NOP);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall(1);
    test_stall(3);
    test_redirect_stall();
    test_misalign();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the 5-stage RV32I core, upstream of decode and the immediate extension unit.
- Owns the PC and issues word reads to the synchronous instruction memory, which has 1-cycle read latency.
- Holds the IF/ID pipeline register (inst, pc, pc+4, valid) that feeds decode.
- Handles hazard-unit stalls without losing an in-flight read, branch/jump redirects with flush, and misaligned-target trapping.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction presented when no valid instruction is available (addi x0,x0,0).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hazard unit: hold the IF/ID register and issue no new fetch.
- redirect_i  input  1  branch taken or jump resolved: flush and refetch.
- redirect_pc_i  input  32  target address for redirect_i.
- imem_rd_en  output  1  instruction memory read strobe.
- imem_addr  output  32  byte address of the fetch, word aligned.
- imem_rdata  input  32  read data, valid the cycle after imem_rd_en.
- if_inst  output  32  instruction to decode.
- if_pc  output  32  PC of if_inst.
- if_pc_plus4  output  32  if_pc + 4, wrapping modulo 2^32.
- if_valid  output  1  IF/ID entry holds a real instruction.
- if_misalign  output  1  entry is a misaligned-fetch trap record.

Behaviour:
- Reset: asynchronous, active low.
  - pc_q=RESET_PC; state=RUN; request tracker (req_vld_q, req_pc_q, req_mis_q) cleared; skid buffer empty.
  - if_inst=NOP_INST, if_pc=0, if_pc_plus4=4, if_valid=0, if_misalign=0.
  - imem_rd_en=0 while rst_n is low.
- State RUN, issue rule: issue = ~stall_i & ~redirect_i.
  - If issue and pc_q[1:0]==0: imem_rd_en=1, imem_addr=pc_q. At the clock edge, pc_q<=pc_q+4 (wraps), req_vld_q<=1, req_pc_q<=pc_q, req_mis_q<=0.
  - If issue and pc_q[1:0]!=0: imem_rd_en=0. At the clock edge, req_vld_q<=1, req_mis_q<=1, req_pc_q<=pc_q, state<=TRAP.
  - If no issue: req_vld_q<=0.
- State TRAP:
  - No fetches are issued and pc_q holds.
  - The unit remains in TRAP until redirect_i, which returns it to RUN.
- Response path: a response is present when req_vld_q=1. Its data is imem_rdata, or NOP_INST when req_mis_q=1.
  - Not stalled: the IF/ID register loads from the skid buffer if it is full (and the skid empties), otherwise from the response. if_valid<=(source valid).
  - Stalled: the IF/ID register holds and the response is captured into the skid buffer.
  - The skid buffer is never full while a new response arrives, because stall blocks issue. The bench asserts this invariant.
- Redirect: redirect_i has the highest priority and overrides stall_i.
  - pc_q<=redirect_pc_i; the skid buffer empties; any in-flight response is discarded (req_vld_q<=0).
  - if_valid<=0, if_misalign<=0, if_inst<=NOP_INST.
  - No fetch is issued in the redirect cycle; state<=RUN.
- Latency:
  - Redirect in cycle t: fetch of the target in t+1; if_valid=1 with if_pc=target in t+3, assuming no stall.
  - After reset release (cycle 1 = first cycle with rst_n high): fetch of RESET_PC in cycle 1; first valid output in cycle 3.
- Throughput: one instruction per cycle in steady state; no bubble when a stall is released.
- Stall mid-operation: no instruction is lost or duplicated. Order out equals order fetched.
- Reset mid-operation: all state is discarded immediately and the in-flight read is ignored.

Test Plan:
1. Reset, RESET_PC=0x100, no stall → if_pc sequence 0x100, 0x104, 0x108 starting in cycle 3, if_inst matching the memory image, if_pc_plus4=if_pc+4.
2. Single-cycle stall_i in steady state → IF/ID holds for one cycle, then resumes with the next sequential PC; no gap, no duplicate (skid path exercised).
3. Multi-cycle stall of 3 cycles → exactly one skid capture, imem_rd_en=0 for 3 cycles, sequence intact afterwards.
4. redirect_i with redirect_pc_i=0x200 while stall_i=1 and a read is in flight → next cycle if_valid=0; if_pc=0x200 valid 3 cycles after the redirect; the stale instruction never appears.
5. Redirect to 0x202 → one entry with if_valid=1, if_misalign=1, if_pc=0x202, if_inst=0x00000013; then imem_rd_en stays 0 until a redirect to 0x300, after which fetching resumes at 0x300.
6. PC wrap: RESET_PC=0xFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000; if_pc_plus4=0x0 for the first entry. Also assert rst_n low mid-stream → outputs return to their reset values asynchronously.
